ram_read_arbiter: RTL and testbench
===================================

Name: ram_read_arbiter

Overview:
Shares the single read port of the 64x8 program/data RAM between two requesters: requester 0 is CPU instruction fetch and requester 1 is CPU data/operand read. Sits between the control unit and the RAM. It drives the RAM address and output-enable, registers the RAM output and returns it with a one-cycle acknowledge. Out-of-range addresses are caught and never reach the RAM.

Parameters:
DEPTH, 64, number of valid RAM words; addresses >= DEPTH are out of range.
PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with requester 0 highest.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req0  input  1  requester 0 read request; held high until ack0.
addr0  input  8  requester 0 address; stable while req0 is high.
ack0  output  1  one-cycle pulse: rdata and err are valid for requester 0.
req1  input  1  requester 1 read request; same rules as req0.
addr1  input  8  requester 1 address.
ack1  output  1  one-cycle pulse for requester 1.
rdata  output  8  registered read data, shared by both requesters.
err  output  1  valid with ack: address was out of range.
mem_add  output  8  RAM address.
mem_oe  output  1  RAM output enable.
mem_o  input  8  RAM data out; high-Z when mem_oe is 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). All state and outputs are registered.
- Reset values: state=IDLE, mem_add=0x00, mem_oe=0, rdata=0x00, err=0, ack0=ack1=0, rr_last=1 (so requester 0 wins first).
- FSM states: IDLE, READ, DONE.
- IDLE, no request: stay in IDLE; mem_oe=0.
- IDLE, at least one request:
  - Pick a winner by policy and latch winner id.
  - If the winner's address < DEPTH: mem_add<=addr, mem_oe<=1, go to READ.
  - If the address >= DEPTH: mem_oe stays 0, rdata<=0x00, err<=1, go to DONE directly. This is the error path.
- READ (one cycle, mem_oe=1): rdata<=mem_o, err<=0, mem_oe<=0, ackN<=1 for the winner, go to DONE.
- DONE: ackN is high for exactly this cycle. The requester drops reqN here; reqN is ignored in DONE. Clear ack, go to IDLE.
- Latency: request seen in IDLE at cycle T gives ack at T+2 (valid address) or T+1 (error). Throughput is one access per 3 cycles.
- Round-robin (PRIO_MODE=0):
  - If both request, grant the one not equal to rr_last.
  - rr_last updates to the winner on every grant, including error grants.
  - With both held continuously, grants strictly alternate.
- Fixed priority (PRIO_MODE=1): requester 0 always wins a tie; requester 1 may starve. This is accepted.
- Simultaneous events: a request arriving during READ or DONE waits for IDLE. The loser's request stays pending; its address is not sampled until it is granted.
- Request dropped before ack (protocol violation): the access completes anyway and ack is still pulsed.
- mem_add holds its last value when idle. Only mem_oe gates the RAM bus.
- Address compare is 8-bit unsigned against DEPTH; 0x3F is valid and 0x40..0xFF are errors with DEPTH=64.
- Reset mid-operation: abort immediately, return to reset values, no ack is issued. Requesters re-issue after reset.

Optional Feature:
RAM_ARB_STATS_EN:
- Defined: adds outputs gnt_cnt0[7:0] and gnt_cnt1[7:0]. Each is a saturating count of grants per requester, error grants included. Each sticks at 0xFF and resets to 0.
- Undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package toyup_mem_pkg holds:
  - state enum {IDLE, READ, DONE};
  - constants MEM_AW=8, MEM_DW=8, MEM_DEPTH=64;
  - PRIO_RR=0 and PRIO_FIXED=1.
- One sub-module, rr_pick2: combinational 2-way winner selection from req0, req1, rr_last and PRIO_MODE. The FSM and datapath stay in the top module.

Test Plan:
- Single read: RAM preloaded MEM[0x05]=0xA7; req0=1, addr0=0x05 -> mem_oe high for exactly 1 cycle with mem_add=0x05; ack0 at T+2; rdata=0xA7; err=0.
- Contention, round-robin: req0 and req1 held with addr0=0x01 (0x11) and addr1=0x02 (0x22) -> acks alternate 0,1,0,1 every 3 cycles; rdata 0x11, 0x22, ...
- Fixed priority: PRIO_MODE=1 with both held -> only ack0 fires over 10 accesses; drop req0 -> ack1 within 3 cycles.
- Out of range: addr1=0x40 -> ack1 at T+1, err=1, rdata=0x00, mem_oe never asserted; addr1=0x3F reads normally with err=0.
- Reset mid-access: assert rst_n low during READ -> mem_oe, ack0, ack1 and rdata go to 0 asynchronously; no ack after release; a fresh request completes normally.
- With RAM_ARB_STATS_EN: 300 grants to requester 0 -> gnt_cnt0=0xFF (saturated), gnt_cnt1=0x00.

Source files
------------

// File: rtl/toyup_mem_pkg.sv
// Shared types and constants for the 64x8 program/data RAM and its read arbiter.
package toyup_mem_pkg;

  localparam int MEM_AW     = 8;
  localparam int MEM_DW     = 8;
  localparam int MEM_DEPTH  = 64;
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  typedef struct packed {
    logic [MEM_DW-1:0] rdata;
    logic              err;
  } rd_rsp_t;

  // Unsigned compare with one extra bit so a full 256-word DEPTH still works.
  function automatic logic addr_in_range(input logic [MEM_AW-1:0] a,
                                         input logic [MEM_AW:0]   depth);
    return {1'b0, a} < depth;
  endfunction

endpackage

// File: rtl/ram_read_arbiter_rr_pick2.sv
// Two-way combinational winner select: round-robin or fixed priority (req0 highest).
module rr_pick2
  import toyup_mem_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_last,
  output logic o_gnt_vld,
  output logic o_win
);

  logic w_rr_win;
  logic w_fix_win;

  // On a tie, round-robin hands the grant to whoever did not win last.
  assign w_rr_win  = (i_req0 && i_req1) ? ~i_rr_last : i_req1;
  assign w_fix_win = i_req1 && !i_req0;

  assign o_gnt_vld = i_req0 || i_req1;
  assign o_win     = (PRIO_MODE == PRIO_FIXED) ? w_fix_win : w_rr_win;

endmodule

// File: rtl/ram_read_arbiter.sv
// Arbitrates CPU fetch (req0) and operand read (req1) onto the single RAM read port.
// Optional macro RAM_ARB_STATS_EN adds saturating per-requester grant counters.
module ram_read_arbiter
  import toyup_mem_pkg::*;
#(
  parameter int DEPTH     = MEM_DEPTH,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [MEM_AW-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [MEM_AW-1:0] addr1,
  output logic              ack1,
  output logic [MEM_DW-1:0] rdata,
  output logic              err,
  output logic [MEM_AW-1:0] mem_add,
  output logic              mem_oe,
  input  logic [MEM_DW-1:0] mem_o
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1
`endif
);

  localparam logic [MEM_AW:0] DEPTH_L = DEPTH[MEM_AW:0];

  state_t            r_state, w_state_nxt;
  logic              r_rr_last;
  logic              r_win;
  logic              r_ack0, r_ack1;
  logic              r_mem_oe;
  logic [MEM_AW-1:0] r_mem_add;
  rd_rsp_t           r_rsp;

  logic              w_gnt_vld;
  logic              w_win;
  logic [MEM_AW-1:0] w_addr;
  logic              w_addr_ok;
  logic              w_grant;

  rr_pick2 #(.PRIO_MODE(PRIO_MODE)) u_pick (
    .i_req0    (req0),
    .i_req1    (req1),
    .i_rr_last (r_rr_last),
    .o_gnt_vld (w_gnt_vld),
    .o_win     (w_win)
  );

  // Only the winner's address is sampled; the loser's stays pending untouched.
  assign w_addr    = w_win ? addr1 : addr0;
  assign w_addr_ok = addr_in_range(w_addr, DEPTH_L);
  assign w_grant   = (r_state == IDLE) && w_gnt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_vld) w_state_nxt = w_addr_ok ? READ : DONE;
      READ:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= 1'b1;
      r_win     <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_mem_oe  <= 1'b0;
      r_mem_add <= '0;
      r_rsp     <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: if (w_gnt_vld) begin
          r_win     <= w_win;
          r_rr_last <= w_win;
          if (w_addr_ok) begin
            r_mem_add <= w_addr;
            r_mem_oe  <= 1'b1;
          end else begin
            // Error path skips the RAM entirely and acks one cycle early.
            r_rsp  <= '{rdata: '0, err: 1'b1};
            r_ack0 <= ~w_win;
            r_ack1 <= w_win;
          end
        end
        READ: begin
          r_rsp    <= '{rdata: mem_o, err: 1'b0};
          r_mem_oe <= 1'b0;
          r_ack0   <= ~r_win;
          r_ack1   <= r_win;
        end
        default: ;
      endcase
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign rdata   = r_rsp.rdata;
  assign err     = r_rsp.err;
  assign mem_add = r_mem_add;
  assign mem_oe  = r_mem_oe;

`ifdef RAM_ARB_STATS_EN
  logic [7:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_grant) begin
      if (!w_win && r_cnt0 != 8'hFF) r_cnt0 <= r_cnt0 + 8'd1;
      if ( w_win && r_cnt1 != 8'hFF) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign gnt_cnt0 = r_cnt0;
  assign gnt_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Directed cycle-vector bench for ram_read_arbiter (round-robin and fixed-priority instances).
module tb_ram_read_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] addr0, addr1;
  logic       ack0, ack1, err, mem_oe;
  logic [7:0] rdata, mem_add, mem_o;

  logic       f_req0, f_req1;
  logic [7:0] f_addr0, f_addr1;
  logic       f_ack0, f_ack1, f_err, f_mem_oe;
  logic [7:0] f_rdata, f_mem_add, f_mem_o;

`ifdef RAM_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1, f_gnt_cnt0, f_gnt_cnt1;
`endif

  logic [7:0] ram [64];

  int n_vec;
  int n_bad;

  assign mem_o   = mem_oe   ? ram[mem_add[5:0]]   : 8'h00;
  assign f_mem_o = f_mem_oe ? ram[f_mem_add[5:0]] : 8'h00;

  ram_read_arbiter #(.DEPTH(64), .PRIO_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .rdata(rdata), .err(err),
    .mem_add(mem_add), .mem_oe(mem_oe), .mem_o(mem_o)
`ifdef RAM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  ram_read_arbiter #(.DEPTH(64), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(f_req0), .addr0(f_addr0), .ack0(f_ack0),
    .req1(f_req1), .addr1(f_addr1), .ack1(f_ack1),
    .rdata(f_rdata), .err(f_err),
    .mem_add(f_mem_add), .mem_oe(f_mem_oe), .mem_o(f_mem_o)
`ifdef RAM_ARB_STATS_EN
    , .gnt_cnt0(f_gnt_cnt0), .gnt_cnt1(f_gnt_cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       r0;
    logic [7:0] a0;
    logic       r1;
    logic [7:0] a1;
    logic       ea0;
    logic       ea1;
    logic       eoe;
    logic [7:0] eadd;
    logic [7:0] erd;
    logic       eerr;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r0, logic [7:0] a0, logic r1, logic [7:0] a1,
                              logic ea0, logic ea1, logic eoe, logic [7:0] eadd,
                              logic [7:0] erd, logic eerr);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.ea0 = ea0; v.ea1 = ea1; v.eoe = eoe; v.eadd = eadd;
    v.erd = erd; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %02h, expected %02h", nm, idx, act, exp);
    end
  endtask

  task automatic wait_ack(input bit which, input int bound, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(which ? ack1 : ack0) && lat < bound);
  endtask

  initial begin
    int lat, nf0, nf1;

    for (int i = 0; i < 64; i++) ram[i] = 8'(i) ^ 8'h80;
    ram[8'h05] = 8'hA7;
    ram[8'h01] = 8'h11;
    ram[8'h02] = 8'h22;
    ram[8'h3F] = 8'h5C;

    //          r0 a0     r1 a1     a0 a1 oe add    rd     err
    tbl[0]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(1, 8'h05, 0, 8'h00, 0, 0, 1, 8'h05, 8'h00, 0);
    tbl[2]  = mk(1, 8'h05, 0, 8'h00, 1, 0, 0, 8'h05, 8'hA7, 0);
    tbl[3]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h05, 8'h00, 0);
    tbl[4]  = mk(1, 8'h01, 1, 8'h02, 0, 0, 1, 8'h02, 8'h00, 0);
    tbl[5]  = mk(1, 8'h01, 1, 8'h02, 0, 1, 0, 8'h02, 8'h22, 0);
    tbl[6]  = mk(1, 8'h01, 1, 8'h02, 0, 0, 0, 8'h02, 8'h00, 0);
    tbl[7]  = mk(1, 8'h01, 1, 8'h02, 0, 0, 1, 8'h01, 8'h00, 0);
    tbl[8]  = mk(1, 8'h01, 1, 8'h02, 1, 0, 0, 8'h01, 8'h11, 0);
    tbl[9]  = mk(1, 8'h01, 1, 8'h02, 0, 0, 0, 8'h01, 8'h00, 0);
    tbl[10] = mk(1, 8'h01, 1, 8'h02, 0, 0, 1, 8'h02, 8'h00, 0);
    tbl[11] = mk(1, 8'h01, 1, 8'h02, 0, 1, 0, 8'h02, 8'h22, 0);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00, 0);
    tbl[13] = mk(0, 8'h00, 1, 8'h40, 0, 1, 0, 8'h02, 8'h00, 1);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00, 0);
    tbl[15] = mk(0, 8'h00, 1, 8'h3F, 0, 0, 1, 8'h3F, 8'h00, 0);
    tbl[16] = mk(0, 8'h00, 1, 8'h3F, 0, 1, 0, 8'h3F, 8'h5C, 0);
    tbl[17] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h3F, 8'h00, 0);
    tbl[18] = mk(1, 8'hFF, 0, 8'h00, 1, 0, 0, 8'h3F, 8'h00, 1);
    tbl[19] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h3F, 8'h00, 0);
    tbl[20] = mk(1, 8'h05, 0, 8'h00, 0, 0, 1, 8'h05, 8'h00, 0);
    tbl[21] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h05, 8'hA7, 0);
    tbl[22] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h05, 8'h00, 0);
    tbl[23] = mk(1, 8'h01, 1, 8'h02, 0, 0, 1, 8'h02, 8'h00, 0);
    tbl[24] = mk(1, 8'h01, 1, 8'h02, 0, 1, 0, 8'h02, 8'h22, 0);
    tbl[25] = mk(1, 8'h01, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00, 0);
    tbl[26] = mk(1, 8'h01, 0, 8'h00, 0, 0, 1, 8'h01, 8'h00, 0);
    tbl[27] = mk(1, 8'h01, 0, 8'h00, 1, 0, 0, 8'h01, 8'h11, 0);
    tbl[28] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 8'h00, 0);

    n_vec = 0; n_bad = 0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    f_req0 = 0; f_req1 = 0; f_addr0 = 0; f_addr1 = 0;

    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ack0", 0, 8'(ack0), 8'h00);
    chk("rst_ack1", 0, 8'(ack1), 8'h00);
    chk("rst_oe",   0, 8'(mem_oe), 8'h00);
    chk("rst_add",  0, mem_add, 8'h00);
    chk("rst_rdata",0, rdata, 8'h00);
    chk("rst_err",  0, 8'(err), 8'h00);
`ifdef RAM_ARB_STATS_EN
    chk("rst_cnt0", 0, gnt_cnt0, 8'h00);
    chk("rst_cnt1", 0, gnt_cnt1, 8'h00);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Round-robin cycle table: inputs at negedge, outputs checked one edge later.
    for (int i = 0; i < NV; i++) begin
      req0 = tbl[i].r0; addr0 = tbl[i].a0;
      req1 = tbl[i].r1; addr1 = tbl[i].a1;
      @(negedge clk);
      chk("ack0",    i, 8'(ack0),   8'(tbl[i].ea0));
      chk("ack1",    i, 8'(ack1),   8'(tbl[i].ea1));
      chk("mem_oe",  i, 8'(mem_oe), 8'(tbl[i].eoe));
      chk("mem_add", i, mem_add,    tbl[i].eadd);
      if (tbl[i].ea0 || tbl[i].ea1) begin
        chk("rdata", i, rdata,   tbl[i].erd);
        chk("err",   i, 8'(err), 8'(tbl[i].eerr));
      end
    end

    // Asynchronous reset while a read is in flight.
    req0 = 1; addr0 = 8'h05;
    @(negedge clk);
    chk("pre_rst_oe", 0, 8'(mem_oe), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe",    0, 8'(mem_oe), 8'h00);
    chk("arst_rdata", 0, rdata, 8'h00);
    chk("arst_add",   0, mem_add, 8'h00);
    chk("arst_ack",   0, 8'({ack0, ack1}), 8'h00);
    req0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_noack", i, 8'({ack0, ack1, mem_oe}), 8'h00);
    end
    req0 = 1; addr0 = 8'h05;
    wait_ack(1'b0, 6, lat);
    chk("fresh_lat",   0, 8'(lat), 8'd2);
    chk("fresh_rdata", 0, rdata, 8'hA7);
    req0 = 0;
    @(negedge clk);

    // Fixed priority: both held, req0 must take every one of 10 grants.
    f_req0 = 1; f_addr0 = 8'h01; f_req1 = 1; f_addr1 = 8'h02;
    nf0 = 0; nf1 = 0;
    for (int c = 0; c < 40 && nf0 < 10; c++) begin
      @(negedge clk);
      if (f_ack1) nf1++;
      if (f_ack0) begin
        nf0++;
        chk("fp_rdata", nf0, f_rdata, 8'h11);
      end
    end
    chk("fp_ack0_cnt", 0, 8'(nf0), 8'd10);
    chk("fp_ack1_cnt", 0, 8'(nf1), 8'd0);
    f_req0 = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!f_ack1 && lat < 6);
    chk("fp_ack1_lat",   0, 8'(lat), 8'd3);
    chk("fp_ack1_rdata", 0, f_rdata, 8'h22);
    f_req1 = 0;
    @(negedge clk);

`ifdef RAM_ARB_STATS_EN
    // One grant to req0 already since reset; 299 more pushes it past saturation.
    for (int g = 0; g < 299; g++) begin
      req0 = 1; addr0 = 8'(g[5:0]);
      wait_ack(1'b0, 6, lat);
      if (!ack0) chk("stats_ack_timeout", g, 8'(ack0), 8'h01);
      req0 = 0;
      @(negedge clk);
    end
    chk("stats_cnt0", 0, gnt_cnt0, 8'hFF);
    chk("stats_cnt1", 0, gnt_cnt1, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
